// File: rtl/nios2_debug_ocimem.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | nios2_debug_ocimem                                                         |
// | Debug RAM shared by JTAG monitor strobes and a CPU Avalon-MM slave port.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module nios2_debug_ocimem #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [37:0]       jdo,
   input  logic              take_action_ocimem_a,
   input  logic              take_action_ocimem_b,
   input  logic              take_no_action_ocimem_a,
   input  logic [ADDR_W-1:0] avs_address,
   input  logic              avs_read,
   input  logic              avs_write,
   input  logic [31:0]       avs_writedata,
   input  logic [3:0]        avs_byteenable,
   output logic [31:0]       avs_readdata,
   output logic              avs_waitrequest,
   output logic [ADDR_W-1:0] MonAReg,
   output logic [31:0]       MonDReg,
   output logic              monitor_ready,
   output logic              monitor_error
);

   localparam int              DEPTH    = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      J_RD = 2'd1,
      C_RD = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] mon_addr_q, mon_addr_d;
   logic [31:0]       mon_data_q, mon_data_d;
   logic [31:0]       cpu_rdata_q, cpu_rdata_d;
   logic              ready_q, ready_d;
   logic              error_q, error_d;
   logic              jrd_pend_q, jrd_pend_d;
   logic              jwr_pend_q, jwr_pend_d;

   logic [31:0]       mem [DEPTH];
   logic [31:0]       ram_q;

   logic              w_acc_a, w_acc_b, w_acc_n, w_err_set;
   logic              w_ram_we, w_ram_wr, w_ram_re, w_cpu_done;
   logic [ADDR_W-1:0] w_ram_addr;
   logic [31:0]       w_ram_wdata;
   logic [3:0]        w_ram_be;
   logic              w_jdo_unused;

   assign w_jdo_unused = ^{jdo[37:35], jdo[2:0]};

   // ocimem_a is always honoured; the others need an idle monitor and no higher-priority strobe
   assign w_acc_a   = take_action_ocimem_a;
   assign w_acc_b   = take_action_ocimem_b & ~take_action_ocimem_a & ready_q;
   assign w_acc_n   = take_no_action_ocimem_a & ~take_action_ocimem_a &
                      ~take_action_ocimem_b & ready_q;
   assign w_err_set = (take_action_ocimem_a & (take_action_ocimem_b | take_no_action_ocimem_a)) |
                      (take_action_ocimem_b & take_no_action_ocimem_a) |
                      (~take_action_ocimem_a & ~ready_q &
                       (take_action_ocimem_b | take_no_action_ocimem_a));

   always_comb begin
      state_d     = state_q;
      mon_addr_d  = mon_addr_q;
      mon_data_d  = mon_data_q;
      cpu_rdata_d = cpu_rdata_q;
      ready_d     = ready_q;
      error_d     = error_q;
      jrd_pend_d  = jrd_pend_q;
      jwr_pend_d  = jwr_pend_q;
      w_ram_we    = 1'b0;
      w_ram_re    = 1'b0;
      w_ram_addr  = mon_addr_q;
      w_ram_wdata = mon_data_q;
      w_ram_be    = 4'hF;
      w_cpu_done  = 1'b0;

      case (state_q)
         IDLE: begin
            if (jwr_pend_q) begin
               w_ram_we   = 1'b1;
               mon_addr_d = mon_addr_q + ADDR_ONE;
               jwr_pend_d = 1'b0;
               ready_d    = 1'b1;
            end else if (jrd_pend_q) begin
               w_ram_re = 1'b1;
               state_d  = J_RD;
            end else if (avs_write) begin
               w_ram_we    = 1'b1;
               w_ram_addr  = avs_address;
               w_ram_wdata = avs_writedata;
               w_ram_be    = avs_byteenable;
               w_cpu_done  = 1'b1;
            end else if (avs_read) begin
               w_ram_re   = 1'b1;
               w_ram_addr = avs_address;
               state_d    = C_RD;
            end
         end
         J_RD: begin
            mon_data_d = ram_q;
            jrd_pend_d = 1'b0;
            ready_d    = 1'b1;
            state_d    = IDLE;
         end
         C_RD: begin
            cpu_rdata_d = ram_q;
            w_cpu_done  = avs_read;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // A freshly accepted strobe overrides any completion landing in the same cycle
      if (w_acc_a) begin
         mon_addr_d = jdo[ADDR_W+2:3];
         jrd_pend_d = 1'b1;
         ready_d    = 1'b0;
      end else if (w_acc_b) begin
         mon_data_d = jdo[34:3];
         jwr_pend_d = 1'b1;
         ready_d    = 1'b0;
      end else if (w_acc_n) begin
         mon_addr_d = mon_addr_q + ADDR_ONE;
         jrd_pend_d = 1'b1;
         ready_d    = 1'b0;
      end

      if (w_err_set) begin
         error_d = 1'b1;
      end else if (w_acc_a) begin
         error_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         mon_addr_q  <= '0;
         mon_data_q  <= '0;
         cpu_rdata_q <= '0;
         ready_q     <= 1'b1;
         error_q     <= 1'b0;
         jrd_pend_q  <= 1'b0;
         jwr_pend_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         mon_addr_q  <= mon_addr_d;
         mon_data_q  <= mon_data_d;
         cpu_rdata_q <= cpu_rdata_d;
         ready_q     <= ready_d;
         error_q     <= error_d;
         jrd_pend_q  <= jrd_pend_d;
         jwr_pend_q  <= jwr_pend_d;
      end
   end

   assign w_ram_wr = w_ram_we & ~reset;

   always_ff @(posedge clk) begin
      if (w_ram_wr) begin
         for (int b = 0; b < 4; b++) begin
            if (w_ram_be[b]) begin
               mem[w_ram_addr][8*b +: 8] <= w_ram_wdata[8*b +: 8];
            end
         end
      end
      if (w_ram_re) begin
         ram_q <= mem[w_ram_addr];
      end
   end

   // During C_RD the RAM output is presented directly so data is valid while waitrequest is low
   assign avs_readdata    = (state_q == C_RD) ? ram_q : cpu_rdata_q;
   assign avs_waitrequest = reset | ((avs_read | avs_write) & ~w_cpu_done);
   assign MonAReg         = mon_addr_q;
   assign MonDReg         = mon_data_q;
   assign monitor_ready   = ready_q;
   assign monitor_error   = error_q;

endmodule
`default_nettype wire

// File: doc/nios2_debug_ocimem.md
Name: nios2_debug_ocimem

Overview:
System-clock debug-memory stage that consumes the JTAG debug module's decoded strobes (`take_action_ocimem_a/b`, `take_no_action_ocimem_a`) and its `jdo` shift-register data. It owns a single-port on-chip debug RAM and the monitor address/data registers. It returns `MonDReg`, `monitor_ready` and `monitor_error` to the JTAG debug module. It also exposes the same RAM to the CPU through an Avalon-MM slave, arbitrating between JTAG and CPU access.

Parameters:
ADDR_W, 8, word-address width; RAM depth = 2^ADDR_W 32-bit words.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- jdo  in  38  JTAG data-out.
- take_action_ocimem_a  in  1  one-cycle strobe: load address and read.
- take_action_ocimem_b  in  1  one-cycle strobe: write data.
- take_no_action_ocimem_a  in  1  one-cycle strobe: increment address and read.
- avs_address  in  ADDR_W  CPU word address.
- avs_read  in  1  CPU read request.
- avs_write  in  1  CPU write request.
- avs_writedata  in  32  CPU write data.
- avs_byteenable  in  4  CPU byte lanes.
- avs_readdata  out  32  CPU read data.
- avs_waitrequest  out  1  CPU stall.
- MonAReg  out  ADDR_W  monitor address register.
- MonDReg  out  32  monitor data register, returned to the JTAG debug module.
- monitor_ready  out  1  high when no JTAG operation is pending or in flight.
- monitor_error  out  1  sticky strobe-overrun flag.

Behaviour:
- Reset values: MonAReg=0, MonDReg=0, monitor_ready=1, monitor_error=0, avs_readdata=0, FSM=IDLE, JTAG pending flags cleared.
  - avs_waitrequest is 1 while reset is high.
  - RAM contents are not reset.
  - Reset mid-operation drops any pending or in-flight access; no RAM write occurs in the reset cycle.
- Strobe decode (edge at end of cycle t):
  - ocimem_a: MonAReg<=jdo[ADDR_W+2:3]; jrd_pend<=1; monitor_error<=0.
  - ocimem_b: MonDReg<=jdo[34:3]; jwr_pend<=1.
  - no_action_ocimem_a: MonAReg<=MonAReg+1; jrd_pend<=1.
  - monitor_ready<=0 on any accepted strobe.
- Simultaneous strobes: priority a > b > no_action; lower-priority strobes are ignored and monitor_error<=1.
- A strobe arriving while monitor_ready=0 is ignored and sets monitor_error<=1.
  - Exception: an ocimem_a strobe is still accepted and clears error.
- Address arithmetic is modulo 2^ADDR_W; 2^ADDR_W-1 wraps to 0.
- FSM states: IDLE, J_RD, C_RD.
  - IDLE with jwr_pend: RAM[MonAReg]<=MonDReg (full word); MonAReg<=MonAReg+1; jwr_pend<=0; monitor_ready<=1. Stays in IDLE.
  - IDLE with jrd_pend: RAM read issued at MonAReg; go to J_RD.
  - J_RD: MonDReg<=RAM output; jrd_pend<=0; monitor_ready<=1; go to IDLE.
  - IDLE with no JTAG pending and avs_write: write lanes per byteenable; avs_waitrequest=0 in the same cycle.
  - IDLE with no JTAG pending and avs_read (write has priority if both): RAM read issued; avs_waitrequest=1; go to C_RD.
  - C_RD: avs_readdata<=RAM output; avs_waitrequest=0 for that cycle; go to IDLE.
  - Read latency: 2 cycles with 1 wait cycle.
- Arbitration: a pending JTAG op always wins IDLE over a CPU request.
  - The CPU request sees avs_waitrequest=1 and is held until granted.
  - A CPU read already in C_RD completes before the JTAG op.
- avs_waitrequest=1 whenever avs_read|avs_write is asserted and the access is not completing this cycle; it is 0 when idle.
- JTAG-op latency from strobe:
  - Write: strobe at t, RAM updated at end of t+1, monitor_ready=1 at t+2.
  - Read: strobe at t, MonDReg valid and monitor_ready=1 at t+3, provided no CPU read is in flight.

Test Plan:
- Reset, then ocimem_a with jdo[10:3]=8'h10 and RAM[0x10]=32'hDEADBEEF → MonAReg=0x10; MonDReg=DEADBEEF and monitor_ready=1 three cycles after the strobe; monitor_error=0.
- ocimem_b with jdo[34:3]=32'hCAFEF00D at MonAReg=0xFF → RAM[0xFF]=CAFEF00D; MonAReg wraps to 0x00. A subsequent CPU read of 0xFF returns CAFEF00D after 1 wait cycle.
- CPU write 32'h11223344 with byteenable=4'b0101 to a word holding 0xAABBCCDD → word reads back 0xAA22CC44; zero wait cycles on the write.
- CPU read held while ocimem_b and no_action strobes arrive → the JTAG write completes first; waitrequest stays high until the JTAG ops drain; the CPU then gets correct data.
- ocimem_b and no_action asserted in the same cycle → write accepted, no increment-read, monitor_error=1. A following ocimem_a clears monitor_error to 0.
- Assert reset during J_RD → monitor_ready=1, MonDReg=0, FSM=IDLE; no RAM change and no stale MonDReg capture after reset.
